// File: rtl/axi4_full_rd2umi_pkg.sv
// Shared constants and types for the AXI4 read-channel to UMI bridge.
// Holds the UMI opcode and command field positions, the AXI burst and
// response encodings, the bridge FSM state type and a size-clamp helper.
package axi4_full_rd2umi_pkg;

  // UMI command opcodes
  localparam logic [4:0] UMI_REQ_READ   = 5'h01;
  localparam logic [4:0] UMI_RESP_READ  = 5'h02;
  localparam logic [4:0] UMI_REQ_WRITE  = 5'h03;
  localparam logic [4:0] UMI_RESP_WRITE = 5'h04;

  // UMI command field layout (32-bit base command)
  localparam int UMI_CMD_W   = 32;
  localparam int UMI_OPC_LSB = 0;
  localparam int UMI_OPC_W   = 5;
  localparam int UMI_ERR_LSB = 25;
  localparam int UMI_ERR_W   = 2;

  // AXI burst types
  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  // AXI response codes
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_UMI_READ  = 2'd1,
    ST_WAIT_RESP = 2'd2,
    ST_SEND_R    = 2'd3
  } state_t;

  // Beats wider than the data bus are narrowed to the bus width.
  function automatic logic [2:0] eff_size(input logic [2:0] arsize,
                                          input logic [2:0] max_size);
    return (arsize > max_size) ? max_size : arsize;
  endfunction

endpackage

// File: rtl/axi4_full_rd2umi_if.sv
// Bundle of the AXI4 AR/R channels and the UMI host request/response
// channels seen by the bridge.
//   slave  : bridge view (AXI slave, UMI requester)
//   master : environment view (AXI master, UMI fabric)
interface axi4_full_rd2umi_if #(
  parameter int CW  = 32,
  parameter int DW  = 128,
  parameter int AW  = 64,
  parameter int IDW = 8
);
  // AXI read address channel
  logic [IDW-1:0] s_axi_arid;
  logic [AW-1:0]  s_axi_araddr;
  logic [7:0]     s_axi_arlen;
  logic [2:0]     s_axi_arsize;
  logic [1:0]     s_axi_arburst;
  logic           s_axi_arlock;
  logic [3:0]     s_axi_arcache;
  logic [2:0]     s_axi_arprot;
  logic [3:0]     s_axi_arqos;
  logic           s_axi_arvalid;
  logic           s_axi_arready;
  // AXI read data channel
  logic [IDW-1:0] s_axi_rid;
  logic [DW-1:0]  s_axi_rdata;
  logic [1:0]     s_axi_rresp;
  logic           s_axi_rlast;
  logic           s_axi_rvalid;
  logic           s_axi_rready;
  // UMI host request
  logic           uhost_req_valid;
  logic           uhost_req_ready;
  logic [CW-1:0]  uhost_req_cmd;
  logic [AW-1:0]  uhost_req_dstaddr;
  logic [AW-1:0]  uhost_req_srcaddr;
  logic [DW-1:0]  uhost_req_data;
  // UMI host response
  logic           uhost_resp_valid;
  logic           uhost_resp_ready;
  logic [CW-1:0]  uhost_resp_cmd;
  logic [AW-1:0]  uhost_resp_dstaddr;
  logic [AW-1:0]  uhost_resp_srcaddr;
  logic [DW-1:0]  uhost_resp_data;

  modport slave (
    input  s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst,
           s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos, s_axi_arvalid,
           s_axi_rready, uhost_req_ready, uhost_resp_valid, uhost_resp_cmd,
           uhost_resp_dstaddr, uhost_resp_srcaddr, uhost_resp_data,
    output s_axi_arready, s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast,
           s_axi_rvalid, uhost_req_valid, uhost_req_cmd, uhost_req_dstaddr,
           uhost_req_srcaddr, uhost_req_data, uhost_resp_ready
  );

  modport master (
    output s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst,
           s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos, s_axi_arvalid,
           s_axi_rready, uhost_req_ready, uhost_resp_valid, uhost_resp_cmd,
           uhost_resp_dstaddr, uhost_resp_srcaddr, uhost_resp_data,
    input  s_axi_arready, s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast,
           s_axi_rvalid, uhost_req_valid, uhost_req_cmd, uhost_req_dstaddr,
           uhost_req_srcaddr, uhost_req_data, uhost_resp_ready
  );
endinterface

// File: rtl/axi4_full_rd2umi_umi_pack.sv
// umi_pack: assembles a UMI command word from its individual fields.
// Ports:
//   cmd_*_i      in   command fields (opcode, size, len, qos, prot, eom,
//                     eof, ex, user, hostid)
//   packet_cmd_o out  CW-bit packed command (fields in the low 32 bits)
module umi_pack
  import axi4_full_rd2umi_pkg::*;
#(
  parameter int CW = 32
) (
  input  logic [4:0]    cmd_opcode_i,
  input  logic [2:0]    cmd_size_i,
  input  logic [7:0]    cmd_len_i,
  input  logic [3:0]    cmd_qos_i,
  input  logic [1:0]    cmd_prot_i,
  input  logic          cmd_eom_i,
  input  logic          cmd_eof_i,
  input  logic          cmd_ex_i,
  input  logic [1:0]    cmd_user_i,
  input  logic [4:0]    cmd_hostid_i,
  output logic [CW-1:0] packet_cmd_o
);
  logic [UMI_CMD_W-1:0] cmd;

  assign cmd = {cmd_hostid_i, cmd_user_i, cmd_ex_i, cmd_eof_i, cmd_eom_i,
                cmd_prot_i, cmd_qos_i, cmd_len_i, cmd_size_i, cmd_opcode_i};

  assign packet_cmd_o = CW'(cmd);
endmodule

// File: rtl/axi4_full_rd2umi.sv
// axi4_full_rd2umi: converts AXI4 read bursts into a sequence of single-beat
// UMI read requests, one outstanding at a time, and returns each UMI
// response as one AXI R beat.
// Ports:
//   clk     in  clock
//   nreset  in  asynchronous active-low reset
//   bus     slave modport: AXI AR/R channels plus UMI host req/resp channels
module axi4_full_rd2umi
  import axi4_full_rd2umi_pkg::*;
#(
  parameter int            CW       = 32,
  parameter int            DW       = 128,
  parameter int            AW       = 64,
  parameter int            IDW      = 8,
  parameter logic [AW-1:0] HOSTADDR = '0
) (
  input logic                clk,
  input logic                nreset,
  axi4_full_rd2umi_if.slave  bus
);
  localparam int         BYTES    = DW / 8;
  localparam int         LOG2B    = $clog2(BYTES);
  localparam logic [2:0] MAX_SIZE = 3'(LOG2B);

  if (DW > 128 || CW < 32) begin : g_param_check
    $error("axi4_full_rd2umi: DW must be <= 128 and CW must be >= 32");
  end

  state_t         state_q, state_d;
  logic [IDW-1:0] id_q, id_d;
  logic [1:0]     burst_q, burst_d;
  logic [1:0]     prot_q, prot_d;
  logic [3:0]     qos_q, qos_d;
  logic [2:0]     size_q, size_d;
  logic [7:0]     cnt_q, cnt_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [DW-1:0]  rdata_q, rdata_d;
  logic [1:0]     rresp_q, rresp_d;

  logic          arready, rvalid, req_valid, resp_ready;
  logic          ar_fire, req_fire, resp_fire, r_fire;
  logic [AW-1:0] size_mask, addr_aligned, byte_off;
  logic [7:0]    umi_len;
  logic [4:0]    resp_opc;
  logic          unused_inputs;

  assign arready    = (state_q == ST_IDLE);
  assign req_valid  = (state_q == ST_UMI_READ);
  assign resp_ready = (state_q == ST_WAIT_RESP);
  assign rvalid     = (state_q == ST_SEND_R);

  assign ar_fire   = bus.s_axi_arvalid & arready;
  assign req_fire  = req_valid & bus.uhost_req_ready;
  assign resp_fire = bus.uhost_resp_valid & resp_ready;
  assign r_fire    = rvalid & bus.s_axi_rready;

  assign size_mask    = (AW'(1) << size_q) - AW'(1);
  assign addr_aligned = addr_q & ~size_mask;
  // Byte lane of the current address within the data bus; UMI returns data
  // LSB-aligned, AXI expects it on its natural lanes.
  assign byte_off     = addr_q & AW'(BYTES - 1);
  assign umi_len      = 8'((9'd1 << size_q) - 9'd1);
  assign resp_opc     = bus.uhost_resp_cmd[UMI_OPC_LSB +: UMI_OPC_W];

  // State register
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (ar_fire)   state_d = ST_UMI_READ;
      ST_UMI_READ:  if (req_fire)  state_d = ST_WAIT_RESP;
      ST_WAIT_RESP: if (resp_fire) state_d = ST_SEND_R;
      ST_SEND_R:    if (r_fire)    state_d = (cnt_q == 8'd0) ? ST_IDLE : ST_UMI_READ;
      default:                     state_d = ST_IDLE;
    endcase
  end

  // Datapath next-state
  always_comb begin
    id_d    = id_q;
    burst_d = burst_q;
    prot_d  = prot_q;
    qos_d   = qos_q;
    size_d  = size_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rdata_d = rdata_q;
    rresp_d = rresp_q;
    if (ar_fire) begin
      id_d    = bus.s_axi_arid;
      burst_d = bus.s_axi_arburst;
      prot_d  = bus.s_axi_arprot[1:0];
      qos_d   = bus.s_axi_arqos;
      size_d  = eff_size(bus.s_axi_arsize, MAX_SIZE);
      cnt_d   = bus.s_axi_arlen;
      addr_d  = bus.s_axi_araddr;
    end
    if (resp_fire) begin
      rdata_d = bus.uhost_resp_data << {byte_off, 3'b000};
      // Error status is taken fresh from every response.
      rresp_d = (resp_opc != UMI_RESP_READ) ? AXI_RESP_SLVERR
                                            : bus.uhost_resp_cmd[UMI_ERR_LSB +: UMI_ERR_W];
    end
    if (r_fire) begin
      cnt_d = cnt_q - 8'd1;
      // FIXED and WRAP bursts re-read the same address every beat.
      if (burst_q == AXI_BURST_INCR) addr_d = addr_aligned + (AW'(1) << size_q);
    end
  end

  // Datapath registers carry no reset; they are always loaded before use.
  always_ff @(posedge clk) begin
    id_q    <= id_d;
    burst_q <= burst_d;
    prot_q  <= prot_d;
    qos_q   <= qos_d;
    size_q  <= size_d;
    cnt_q   <= cnt_d;
    addr_q  <= addr_d;
    rdata_q <= rdata_d;
    rresp_q <= rresp_d;
  end

  umi_pack #(.CW(CW)) u_umi_pack (
    .cmd_opcode_i (UMI_REQ_READ),
    .cmd_size_i   (3'd0),
    .cmd_len_i    (umi_len),
    .cmd_qos_i    (qos_q),
    .cmd_prot_i   (prot_q),
    .cmd_eom_i    (1'b1),
    .cmd_eof_i    (1'b0),
    .cmd_ex_i     (1'b0),
    .cmd_user_i   (2'b00),
    .cmd_hostid_i (5'd0),
    .packet_cmd_o (bus.uhost_req_cmd)
  );

  assign bus.s_axi_arready     = arready;
  assign bus.s_axi_rvalid      = rvalid;
  assign bus.s_axi_rid         = id_q;
  assign bus.s_axi_rdata       = rdata_q;
  assign bus.s_axi_rresp       = rresp_q;
  assign bus.s_axi_rlast       = (cnt_q == 8'd0);
  assign bus.uhost_req_valid   = req_valid;
  assign bus.uhost_req_dstaddr = addr_aligned;
  assign bus.uhost_req_srcaddr = HOSTADDR;
  assign bus.uhost_req_data    = '0;
  assign bus.uhost_resp_ready  = resp_ready;

  assign unused_inputs = ^{bus.s_axi_arlock, bus.s_axi_arcache, bus.s_axi_arprot[2],
                           bus.uhost_resp_dstaddr, bus.uhost_resp_srcaddr,
                           bus.uhost_resp_cmd};
endmodule

// File: tb/tb_axi4_full_rd2umi.sv
// Directed bench for axi4_full_rd2umi: acts as AXI master and UMI fabric,
// with expected requests, responses to drive and expected R beats queued
// when each AR is issued.
module tb_axi4_full_rd2umi;
  localparam int          CW   = 32;
  localparam int          DW   = 128;
  localparam int          AW   = 64;
  localparam int          IDW  = 8;
  localparam logic [63:0] HOST = 64'h0000_00AB_CDEF_0120;

  logic clk;
  logic nreset;
  int   total = 0;
  int   bad   = 0;

  axi4_full_rd2umi_if #(.CW(CW), .DW(DW), .AW(AW), .IDW(IDW)) ifc ();

  axi4_full_rd2umi #(.CW(CW), .DW(DW), .AW(AW), .IDW(IDW), .HOSTADDR(HOST)) dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (ifc)
  );

  typedef struct { logic [63:0] dst; logic [31:0] cmd; } req_exp_t;
  typedef struct { logic [127:0] data; logic [31:0] cmd; } resp_drv_t;
  typedef struct { logic [127:0] data; logic [1:0] resp; logic last; logic [7:0] id; } beat_exp_t;

  req_exp_t  req_q[$];
  resp_drv_t drv_q[$];
  beat_exp_t beat_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached total=%0d", total);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_burst(input logic [7:0] id, input logic [63:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input logic [2:0] prot,
                          input logic [3:0] qos, input logic [127:0] seed,
                          input int err_beat, input logic [1:0] err_val, input int wr_beat,
                          input int hold_beat, input int abort_beat);
    logic [63:0]  a, al;
    logic [2:0]   eff;
    logic [127:0] d, m;
    logic [4:0]   opc;
    logic [1:0]   e;
    req_exp_t     rq;
    resp_drv_t    dr;
    beat_exp_t    bt;
    bit           ok;

    // Reference model of the whole burst
    eff = (size > 3'd4) ? 3'd4 : size;
    a   = addr;
    for (int k = 0; k <= int'(len); k++) begin
      al     = a & ~((64'd1 << eff) - 64'd1);
      rq.dst = al;
      rq.cmd = 32'h0000_0001 | (32'((1 << eff) - 1) << 8) | (32'(qos) << 16)
             | (32'(prot[1:0]) << 20) | (32'd1 << 22);
      req_q.push_back(rq);
      m   = (128'd1 << (8 << eff)) - 128'd1;
      d   = (seed + 128'(k) * 128'h0101_0101_0101_0101_0101_0101_0101_0101) & m;
      opc = (k == wr_beat) ? 5'h04 : 5'h02;
      e   = (k == err_beat) ? err_val : 2'b00;
      dr.data = d;
      dr.cmd  = 32'(opc) | (32'(e) << 25);
      drv_q.push_back(dr);
      bt.data = d << (8 * a[3:0]);
      bt.resp = (opc != 5'h02) ? 2'b10 : e;
      bt.last = (k == int'(len));
      bt.id   = id;
      beat_q.push_back(bt);
      if (burst == 2'b01) a = al + (64'd1 << eff);
    end

    check("arready_idle", ifc.s_axi_arready, 1);
    ifc.s_axi_arid    = id;
    ifc.s_axi_araddr  = addr;
    ifc.s_axi_arlen   = len;
    ifc.s_axi_arsize  = size;
    ifc.s_axi_arburst = burst;
    ifc.s_axi_arprot  = prot;
    ifc.s_axi_arqos   = qos;
    ifc.s_axi_arvalid = 1'b1;
    @(posedge clk); #1;
    ifc.s_axi_arvalid = 1'b0;
    check("ar_to_req_latency", ifc.uhost_req_valid, 1);
    check("arready_busy", ifc.s_axi_arready, 0);

    for (int k = 0; k <= int'(len); k++) begin
      ok = 1'b0;
      for (int c = 0; c < 20 && !ok; c++) begin
        if (ifc.uhost_req_valid) ok = 1'b1;
        else begin @(posedge clk); #1; end
      end
      check("req_wait", ok, 1);
      if (!ok) begin
        req_q.delete(); drv_q.delete(); beat_q.delete();
        return;
      end
      rq = req_q.pop_front();
      check("req_dstaddr", ifc.uhost_req_dstaddr, rq.dst);
      check("req_cmd", ifc.uhost_req_cmd, rq.cmd);
      check("req_srcaddr", ifc.uhost_req_srcaddr, HOST);
      check("req_data", ifc.uhost_req_data, 0);
      check("resp_ready_early", ifc.uhost_resp_ready, 0);
      ifc.uhost_req_ready = 1'b1;
      @(posedge clk); #1;
      ifc.uhost_req_ready = 1'b0;
      check("req_drop", ifc.uhost_req_valid, 0);
      check("resp_ready", ifc.uhost_resp_ready, 1);

      if (k == abort_beat) begin
        nreset = 1'b0;
        #1;
        check("rst_async_arready", ifc.s_axi_arready, 1);
        check("rst_async_rvalid", ifc.s_axi_rvalid, 0);
        check("rst_async_req_valid", ifc.uhost_req_valid, 0);
        check("rst_async_resp_ready", ifc.uhost_resp_ready, 0);
        @(posedge clk); #1;
        check("rst_arready_next", ifc.s_axi_arready, 1);
        check("rst_rvalid_next", ifc.s_axi_rvalid, 0);
        nreset = 1'b1;
        req_q.delete(); drv_q.delete(); beat_q.delete();
        @(posedge clk); #1;
        check("post_rst_arready", ifc.s_axi_arready, 1);
        check("post_rst_no_req", ifc.uhost_req_valid, 0);
        check("post_rst_no_r", ifc.s_axi_rvalid, 0);
        return;
      end

      dr = drv_q.pop_front();
      ifc.uhost_resp_cmd     = dr.cmd;
      ifc.uhost_resp_data    = dr.data;
      ifc.uhost_resp_dstaddr = 64'(HOST);
      ifc.uhost_resp_srcaddr = {$urandom, $urandom};
      ifc.uhost_resp_valid   = 1'b1;
      @(posedge clk); #1;
      ifc.uhost_resp_valid = 1'b0;
      ifc.uhost_resp_data  = {4{$urandom}};
      ifc.uhost_resp_cmd   = 32'h0000_0004 | (32'd3 << 25);
      check("resp_to_r_latency", ifc.s_axi_rvalid, 1);
      check("resp_ready_drop", ifc.uhost_resp_ready, 0);
      bt = beat_q.pop_front();
      check("rdata", ifc.s_axi_rdata, bt.data);
      check("rresp", ifc.s_axi_rresp, bt.resp);
      check("rlast", ifc.s_axi_rlast, bt.last);
      check("rid", ifc.s_axi_rid, bt.id);

      if (k == hold_beat) begin
        repeat (5) begin
          @(posedge clk); #1;
          check("hold_rvalid", ifc.s_axi_rvalid, 1);
          check("hold_rdata", ifc.s_axi_rdata, bt.data);
          check("hold_rresp", ifc.s_axi_rresp, bt.resp);
          check("hold_rlast", ifc.s_axi_rlast, bt.last);
          check("hold_rid", ifc.s_axi_rid, bt.id);
          check("hold_no_req", ifc.uhost_req_valid, 0);
        end
      end

      ifc.s_axi_rready = 1'b1;
      @(posedge clk); #1;
      ifc.s_axi_rready = 1'b0;
      check("r_drop", ifc.s_axi_rvalid, 0);
      if (k == int'(len)) check("back_to_idle", ifc.s_axi_arready, 1);
      else                check("next_req", ifc.uhost_req_valid, 1);
    end
    check("queues_drained", req_q.size() + drv_q.size() + beat_q.size(), 0);
  endtask

  initial begin
    ifc.s_axi_arid         = '0;
    ifc.s_axi_araddr       = '0;
    ifc.s_axi_arlen        = '0;
    ifc.s_axi_arsize       = '0;
    ifc.s_axi_arburst      = '0;
    ifc.s_axi_arlock       = 1'b0;
    ifc.s_axi_arcache      = 4'h3;
    ifc.s_axi_arprot       = '0;
    ifc.s_axi_arqos        = '0;
    ifc.s_axi_arvalid      = 1'b0;
    ifc.s_axi_rready       = 1'b0;
    ifc.uhost_req_ready    = 1'b0;
    ifc.uhost_resp_valid   = 1'b0;
    ifc.uhost_resp_cmd     = '0;
    ifc.uhost_resp_dstaddr = '0;
    ifc.uhost_resp_srcaddr = '0;
    ifc.uhost_resp_data    = '0;
    nreset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_arready", ifc.s_axi_arready, 1);
    check("reset_rvalid", ifc.s_axi_rvalid, 0);
    check("reset_req_valid", ifc.uhost_req_valid, 0);
    check("reset_resp_ready", ifc.uhost_resp_ready, 0);
    nreset = 1'b1;
    @(posedge clk); #1;

    // INCR 4 x 16 bytes from 0x1000
    do_burst(8'h11, 64'h1000, 8'd3, 3'd4, 2'b01, 3'b010, 4'h5,
             128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0, -1, 2'b00, -1, -1, -1);
    // FIXED 2 x 4 bytes at 0x40
    do_burst(8'h22, 64'h40, 8'd1, 3'd2, 2'b00, 3'b001, 4'h0,
             128'hCAFE_F00D, -1, 2'b00, -1, -1, -1);
    // Unaligned 2-byte read lands on byte lanes 6..7
    do_burst(8'h33, 64'h1006, 8'd0, 3'd1, 2'b01, 3'b000, 4'h0,
             128'hBEEF, -1, 2'b00, -1, -1, -1);
    // Error on beat 2 only
    do_burst(8'h44, 64'h2000, 8'd3, 3'd3, 2'b01, 3'b011, 4'hA,
             128'h1122_3344_5566_7788, 2, 2'b11, -1, -1, -1);
    // Write-response opcode on beat 1
    do_burst(8'h55, 64'h2100, 8'd1, 3'd2, 2'b01, 3'b000, 4'h1,
             128'h0BAD_0001, -1, 2'b00, 1, -1, -1);
    // WRAP burst with R back-pressure on beat 1
    do_burst(8'h66, 64'h3040, 8'd2, 3'd3, 2'b10, 3'b000, 4'h2,
             128'h5A5A_A5A5_0000_FFFF, -1, 2'b00, -1, 1, -1);
    // Oversized ARSIZE narrowed to the bus width
    do_burst(8'h77, 64'h4000, 8'd1, 3'd7, 2'b01, 3'b000, 4'h0,
             128'hDEAD_BEEF_0000_0000_0000_0000_0000_0001, -1, 2'b00, -1, -1, -1);
    // Address wraps past the top of the address space
    do_burst(8'h88, 64'hFFFF_FFFF_FFFF_FFF0, 8'd1, 3'd4, 2'b01, 3'b000, 4'h0,
             128'h1234, -1, 2'b00, -1, -1, -1);
    // Reset in the middle of a burst, then a clean burst
    do_burst(8'h99, 64'h5000, 8'd3, 3'd2, 2'b01, 3'b000, 4'h0,
             128'h7777, -1, 2'b00, -1, -1, 1);
    do_burst(8'hAA, 64'h6000, 8'd0, 3'd2, 2'b01, 3'b000, 4'h0,
             128'h6666_6666, -1, 2'b00, -1, -1, -1);
    // Longest burst: 256 byte beats
    do_burst(8'hBB, 64'h7000, 8'd255, 3'd0, 2'b01, 3'b000, 4'h0,
             128'h3, -1, 2'b00, -1, -1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
